// File: rtl/demux_bin_stream.sv
// Registered valid/ready demux: one input stream routed to WIDTH outputs by binary index.
// Optional one-entry skid buffer via `define DEMUX_BIN_STREAM_SKID_EN.
module demux_bin_stream #(
  parameter type DAT_T = logic [8-1:0],
  parameter int  WIDTH = 16,
  localparam int WIDTH_LOG = $clog2(WIDTH)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 i_vld,
  output logic                 i_rdy,
  input  logic [WIDTH_LOG-1:0] i_bin,
  input  DAT_T                 i_dat,
  output logic [WIDTH-1:0]     o_vld,
  input  logic [WIDTH-1:0]     o_rdy,
  output DAT_T                 o_dat,
  output logic                 err
);

  logic                 vld_q;
  logic [WIDTH_LOG-1:0] bin_q;
  DAT_T                 dat_q;
  logic                 sel_rdy;
  logic                 drain;
  logic                 in_range;
  logic                 acc;
  logic                 load;

  always_comb begin
    sel_rdy = 1'b0;
    o_vld   = '0;
    for (int k = 0; k < WIDTH; k++) begin
      if (bin_q == WIDTH_LOG'(k)) begin
        sel_rdy  = o_rdy[k];
        o_vld[k] = vld_q;
      end
    end
  end

  assign o_dat    = dat_q;
  assign drain    = vld_q && sel_rdy;
  assign in_range = 32'(i_bin) < WIDTH;
  assign acc      = i_vld && i_rdy;
  assign load     = acc && in_range;

`ifdef DEMUX_BIN_STREAM_SKID_EN
  logic                 skid_vld;
  logic [WIDTH_LOG-1:0] skid_bin;
  DAT_T                 skid_dat;

  // Ready is purely registered: no path from o_rdy.
  assign i_rdy = !skid_vld;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q    <= 1'b0;
      bin_q    <= '0;
      dat_q    <= '0;
      err      <= 1'b0;
      skid_vld <= 1'b0;
      skid_bin <= '0;
      skid_dat <= '0;
    end else begin
      err <= acc && !in_range;
      if (!vld_q || drain) begin
        if (skid_vld) begin
          vld_q    <= 1'b1;
          bin_q    <= skid_bin;
          dat_q    <= skid_dat;
          skid_vld <= 1'b0;
        end else if (load) begin
          vld_q <= 1'b1;
          bin_q <= i_bin;
          dat_q <= i_dat;
        end else begin
          vld_q <= 1'b0;
        end
      end else if (load) begin
        skid_vld <= 1'b1;
        skid_bin <= i_bin;
        skid_dat <= i_dat;
      end
    end
  end
`else
  assign i_rdy = !vld_q || sel_rdy;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      vld_q <= 1'b0;
      bin_q <= '0;
      dat_q <= '0;
      err   <= 1'b0;
    end else begin
      err <= acc && !in_range;
      if (load) begin
        vld_q <= 1'b1;
        bin_q <= i_bin;
        dat_q <= i_dat;
      end else if (drain) begin
        vld_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_demux_bin_stream.sv
// Directed and scoreboarded bench for demux_bin_stream.
// Two instances share inputs: WIDTH=16 and WIDTH=12 (out-of-range selects).
module tb_demux_bin_stream;

`ifdef DEMUX_BIN_STREAM_SKID_EN
  localparam bit SKID = 1'b1;
`else
  localparam bit SKID = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        i_vld;
  logic [3:0]  i_bin;
  logic [7:0]  i_dat;
  logic [15:0] o_rdy;

  logic        i_rdy16, err16;
  logic [15:0] o_vld16;
  logic [7:0]  o_dat16;
  logic        i_rdy12, err12;
  logic [11:0] o_vld12;
  logic [7:0]  o_dat12;

  int checks = 0;
  int failures = 0;

  always #5 clk = ~clk;

  demux_bin_stream #(.WIDTH(16)) dut16 (
    .clk(clk), .rst_n(rst_n),
    .i_vld(i_vld), .i_rdy(i_rdy16),
    .i_bin(i_bin), .i_dat(i_dat),
    .o_vld(o_vld16), .o_rdy(o_rdy),
    .o_dat(o_dat16), .err(err16)
  );

  demux_bin_stream #(.WIDTH(12)) dut12 (
    .clk(clk), .rst_n(rst_n),
    .i_vld(i_vld), .i_rdy(i_rdy12),
    .i_bin(i_bin), .i_dat(i_dat),
    .o_vld(o_vld12), .o_rdy(o_rdy[11:0]),
    .o_dat(o_dat12), .err(err12)
  );

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    i_vld = 1'b0;
    i_bin = '0;
    i_dat = '0;
    o_rdy = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  logic [11:0] q[$];
  logic [11:0] exp_beat;
  logic        acc, exp_err, acc_prev, nonempty;

  initial begin
    do_reset();
    #1;
    chk("rst_vld16", o_vld16, 0);
    chk("rst_dat16", o_dat16, 0);
    chk("rst_err16", err16, 0);
    chk("rst_rdy16", i_rdy16, 1);
    chk("rst_vld12", o_vld12, 0);
    chk("rst_rdy12", i_rdy12, 1);

    // Sweep all selects back to back, downstream always ready.
    o_rdy = '1;
    for (int b = 0; b < 16; b++) begin
      i_vld = 1'b1;
      i_bin = 4'(b);
      i_dat = 8'(b);
      #1;
      chk("swp_rdy", i_rdy16, 1);
      chk("swp_err16", err16, 0);
      if (b > 0) begin
        chk("swp_vld", o_vld16, 32'(16'd1 << (b - 1)));
        chk("swp_dat", o_dat16, 32'(b - 1));
        chk("swp_err12", err12, 32'(b - 1 >= 12));
        chk("swp_vld12", o_vld12,
            (b - 1 < 12) ? 32'(12'd1 << (b - 1)) : 32'd0);
      end
      step();
    end
    i_vld = 1'b0;
    #1;
    chk("swp_last", o_vld16, 32'h8000);
    chk("swp_lastd", o_dat16, 32'h0f);
    chk("swp_err12l", err12, 1);
    chk("swp_vld12l", o_vld12, 0);
    step();

    // Out-of-range on the 12-wide instance, then a normal beat.
    i_vld = 1'b1; i_bin = 4'd13; i_dat = 8'h33;
    step();
    i_bin = 4'd11; i_dat = 8'h11;
    #1;
    chk("oor_err", err12, 1);
    chk("oor_vld", o_vld12, 0);
    chk("oor_idle_dat", o_dat12, 32'h0b);
    step();
    i_vld = 1'b0;
    #1;
    chk("oor_err_clr", err12, 0);
    chk("oor_next_vld", o_vld12, 32'h800);
    chk("oor_next_dat", o_dat12, 32'h11);
    step();

    // Stall on destination 5.
    do_reset();
    i_vld = 1'b1; i_bin = 4'd5; i_dat = 8'ha5;
    step();
    i_bin = 4'd6; i_dat = 8'h66;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("stl_vld", o_vld16, 32'h0020);
      chk("stl_dat", o_dat16, 32'ha5);
      chk("stl_rdy", i_rdy16, 32'(SKID && c == 0));
      step();
    end
    o_rdy = '1;
    #1;
    chk("stl_rel_rdy", i_rdy16, 32'(!SKID));
    step();
    i_vld = 1'b0;
    #1;
    chk("stl_next_vld", o_vld16, 32'h0040);
    chk("stl_next_dat", o_dat16, 32'h66);
    step();
    #1;
    chk("stl_empty", o_vld16, 0);

    // Other destination ready while selected one stalls.
    do_reset();
    i_vld = 1'b1; i_bin = 4'd2; i_dat = 8'h22;
    step();
    i_vld = 1'b0;
    o_rdy = 16'h0080;
    #1;
    chk("sw_rdy", i_rdy16, 32'(SKID));
    step();
    #1;
    chk("sw_hold", o_vld16, 32'h0004);
    chk("sw_dat", o_dat16, 32'h22);
    o_rdy = 16'h0084;
    i_vld = 1'b1; i_bin = 4'd7; i_dat = 8'h77;
    #1;
    chk("sw_rdy2", i_rdy16, 1);
    step();
    i_vld = 1'b0;
    #1;
    chk("sw_vld7", o_vld16, 32'h0080);
    chk("sw_dat7", o_dat16, 32'h77);
    step();
    #1;
    chk("sw_empty", o_vld16, 0);

    // Reset with a stalled beat and an out-of-range beat presented.
    do_reset();
    i_vld = 1'b1; i_bin = 4'd3; i_dat = 8'h3c;
    step();
    i_vld = 1'b0;
    #1;
    chk("mr_pre", o_vld16, 32'h0008);
    rst_n = 1'b0;
    i_vld = 1'b1; i_bin = 4'd13; i_dat = 8'h33;
    step();
    rst_n = 1'b1;
    i_vld = 1'b0;
    #1;
    chk("mr_vld", o_vld16, 0);
    chk("mr_dat", o_dat16, 0);
    chk("mr_err12", err12, 0);
    chk("mr_rdy", i_rdy16, 1);
    o_rdy = '1;
    step();
    #1;
    chk("mr_lost", o_vld16, 0);

    // Random traffic on the 12-wide instance against an in-order queue.
    do_reset();
    exp_err = 1'b0;
    acc_prev = 1'b0;
    for (int n = 0; n < 3004; n++) begin
      if (n >= 3000) begin
        i_vld = 1'b0;
        o_rdy = '1;
      end else begin
        if (!(i_vld && !acc_prev)) begin
          i_vld = $urandom_range(0, 3) != 0;
          i_bin = 4'($urandom_range(0, 15));
          i_dat = 8'($urandom);
        end
        o_rdy = 16'($urandom);
      end
      #1;
      acc = i_vld && i_rdy12;
      chk("rnd_err", err12, 32'(exp_err));
      chk("rnd_onehot", 32'($onehot0(o_vld12)), 1);
      for (int k = 0; k < 12; k++) begin
        if (o_vld12[k] && o_rdy[k]) begin
          nonempty = q.size() != 0;
          chk("rnd_nonempty", 32'(nonempty), 1);
          if (nonempty) begin
            exp_beat = q.pop_front();
            chk("rnd_beat", {20'd0, k[3:0], o_dat12}, {20'd0, exp_beat});
          end
        end
      end
      if (acc && i_bin < 4'd12) q.push_back({i_bin, i_dat});
      exp_err = acc && i_bin >= 4'd12;
      acc_prev = acc;
      step();
    end
    chk("rnd_left", q.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
